am386sx_bus_master: RTL and testbench

- Initiator end of the 386SX local bus. The southbridge acts as responder on the same bus.
- Turns simple request/response transactions from on-chip logic (bench sequencer, future DMA/test engine) into 386SX non-pipelined bus cycles: ADS#, M/IO#, D/C#, W/R#, BHE#/BLE#, A[23:1], D[15:0], terminated by READY#.
- Yields the bus to HOLD/HLDA arbitration between cycles and aborts cycles that never see READY#.

---
 rtl/am386sx_bus_master.sv | 222 ++++++++++++++++++++++
 tb/tb_am386sx_bus_master.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/am386sx_bus_master.sv
// 386SX local-bus initiator: turns request/response transactions into
// non-pipelined T1/T2 bus cycles with HOLD/HLDA arbitration and READY# timeout.
module am386sx_bus_master #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_mio,
    input  logic        req_dc,
    input  logic        req_lock,
    input  logic [22:0] req_addr,
    input  logic [1:0]  req_be_n,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_rdata,
    output logic        ads_n,
    output logic        lock_n,
    output logic        mio,
    output logic        dc,
    output logic        wr,
    output logic [1:0]  be_n,
    output logic [22:0] addr,
    output logic        bus_oe,
    output logic [15:0] data_out,
    output logic        data_oe,
    input  logic [15:0] data_in,
    input  logic        ready_n,
    input  logic        hold,
    output logic        hlda
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_HOLD = 3'd3,
        S_REJ  = 3'd4
    } state_t;

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] CNT_MAX  = {TO_W{1'b1}};

    state_t          state_q, state_d;
    logic            ads_n_q, ads_n_d;
    logic            lock_n_q, lock_n_d;
    logic            mio_q, mio_d;
    logic            dc_q, dc_d;
    logic            wr_q, wr_d;
    logic [1:0]      be_n_q, be_n_d;
    logic [22:0]     addr_q, addr_d;
    logic            bus_oe_q, bus_oe_d;
    logic [15:0]     data_out_q, data_out_d;
    logic            data_oe_q, data_oe_d;
    logic            hlda_q, hlda_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [15:0]     rsp_rdata_q, rsp_rdata_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    assign req_ready = reset_n & (state_q == S_IDLE) & ~hold;

    // Next-state and registered-output computation for the bus cycle FSM.
    always_comb begin
        state_d     = state_q;
        ads_n_d     = 1'b1;
        lock_n_d    = lock_n_q;
        mio_d       = mio_q;
        dc_d        = dc_q;
        wr_d        = wr_q;
        be_n_d      = be_n_q;
        addr_d      = addr_q;
        bus_oe_d    = bus_oe_q;
        data_out_d  = data_out_q;
        data_oe_d   = data_oe_q;
        hlda_d      = hlda_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (hold) begin
                    state_d   = S_HOLD;
                    hlda_d    = 1'b1;
                    bus_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                end else if (req_valid && (req_be_n == 2'b11)) begin
                    state_d     = S_REJ;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 16'hFFFF;
                end else if (req_valid) begin
                    state_d   = S_T1;
                    ads_n_d   = 1'b0;
                    addr_d    = req_addr;
                    be_n_d    = req_be_n;
                    mio_d     = req_mio;
                    dc_d      = req_dc;
                    wr_d      = req_wr;
                    lock_n_d  = ~req_lock;
                    wdata_d   = req_wdata;
                    data_oe_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T1: begin
                state_d   = S_T2;
                cnt_d     = {TO_W{1'b0}};
                data_oe_d = wr_q;
                if (wr_q) begin
                    data_out_d = wdata_q;
                end else begin
                    data_out_d = data_out_q;
                end
            end
            S_T2: begin
                if (!ready_n) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = wr_q ? 16'h0000 : data_in;
                    lock_n_d    = 1'b1;
                    data_oe_d   = 1'b0;
                    be_n_d      = 2'b11;
                end else if (cnt_q == CNT_LAST) begin
                    // READY# never came: abandon the cycle with an error.
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 16'hFFFF;
                    lock_n_d    = 1'b1;
                    data_oe_d   = 1'b0;
                    be_n_d      = 2'b11;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_HOLD: begin
                if (!hold) begin
                    state_d  = S_IDLE;
                    hlda_d   = 1'b0;
                    bus_oe_d = 1'b1;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_REJ: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ads_n_q     <= 1'b1;
            lock_n_q    <= 1'b1;
            mio_q       <= 1'b0;
            dc_q        <= 1'b0;
            wr_q        <= 1'b0;
            be_n_q      <= 2'b11;
            addr_q      <= 23'd0;
            bus_oe_q    <= 1'b1;
            data_out_q  <= 16'h0000;
            data_oe_q   <= 1'b0;
            hlda_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 16'h0000;
            wdata_q     <= 16'h0000;
            cnt_q       <= {TO_W{1'b0}};
        end else begin
            state_q     <= state_d;
            ads_n_q     <= ads_n_d;
            lock_n_q    <= lock_n_d;
            mio_q       <= mio_d;
            dc_q        <= dc_d;
            wr_q        <= wr_d;
            be_n_q      <= be_n_d;
            addr_q      <= addr_d;
            bus_oe_q    <= bus_oe_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            hlda_q      <= hlda_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ads_n     = ads_n_q;
    assign lock_n    = lock_n_q;
    assign mio       = mio_q;
    assign dc        = dc_q;
    assign wr        = wr_q;
    assign be_n      = be_n_q;
    assign addr      = addr_q;
    assign bus_oe    = bus_oe_q;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;
    assign hlda      = hlda_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_am386sx_bus_master.sv
// Randomized bench for am386sx_bus_master: a transaction-level model predicts
// each cycle's bus phases, latency and response from the request and READY# pattern.
module tb_am386sx_bus_master;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic        req_mio = 1'b0;
    logic        req_dc = 1'b0;
    logic        req_lock = 1'b0;
    logic [22:0] req_addr = 23'd0;
    logic [1:0]  req_be_n = 2'b11;
    logic [15:0] req_wdata = 16'h0000;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] rsp_rdata;
    logic        ads_n;
    logic        lock_n;
    logic        bus_mio;
    logic        bus_dc;
    logic        bus_wr;
    logic [1:0]  be_n;
    logic [22:0] addr;
    logic        bus_oe;
    logic [15:0] data_out;
    logic        data_oe;
    logic [15:0] data_in = 16'h0000;
    logic        ready_n = 1'b1;
    logic        hold = 1'b0;
    logic        hlda;

    int n_vec = 0;
    int n_err = 0;

    am386sx_bus_master #(.TIMEOUT(TMO), .TO_W(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_mio(req_mio), .req_dc(req_dc), .req_lock(req_lock),
        .req_addr(req_addr), .req_be_n(req_be_n), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .ads_n(ads_n), .lock_n(lock_n), .mio(bus_mio), .dc(bus_dc), .wr(bus_wr),
        .be_n(be_n), .addr(addr), .bus_oe(bus_oe),
        .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
        .ready_n(ready_n), .hold(hold), .hlda(hlda)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction from request offer to response; ends on the negedge of the response cycle.
    task automatic run_txn(input logic t_wr, input logic t_mio, input logic t_dc, input logic t_lk,
                           input logic [22:0] a, input logic [1:0] be, input logic [15:0] wd,
                           input int wait_n, input logic [15:0] din, input bit hold_t1);
        int guard;
        int exp_t2;
        int exp_lat;
        bit rej;
        bit tmo;
        bit done;
        logic [15:0] exp_rd;
        rej     = (be == 2'b11);
        tmo     = !rej && (wait_n >= TMO);
        exp_t2  = rej ? 0 : (tmo ? TMO : wait_n + 1);
        exp_lat = rej ? 1 : exp_t2 + 2;
        exp_rd  = (rej || tmo) ? 16'hFFFF : (t_wr ? 16'h0000 : din);
        req_wr = t_wr; req_mio = t_mio; req_dc = t_dc; req_lock = t_lk;
        req_addr = a; req_be_n = be; req_wdata = wd; req_valid = 1'b1;
        #1;
        guard = 0;
        while (!req_ready && guard < 40) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!req_ready) begin
            chk_val("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        done = 1'b0;
        for (int cyc = 1; cyc <= TMO + 6 && !done; cyc++) begin
            if (rsp_valid) begin
                done = 1'b1;
                chk_val("rsp_latency", cyc, exp_lat);
                chk_val("rsp_err", rsp_err, rej || tmo);
                chk_val("rsp_rdata", rsp_rdata, exp_rd);
                chk_val("rsp_idle_bus", {ads_n, lock_n, data_oe, be_n}, {1'b1, 1'b1, 1'b0, 2'b11});
                if (!rej) chk_val("rsp_addr_kept", addr, a);
            end else if (cyc == 1) begin
                chk_val("t1_ads", ads_n, 1'b0);
                chk_val("t1_defn", {bus_mio, bus_dc, bus_wr, lock_n, be_n, addr},
                        {t_mio, t_dc, t_wr, ~t_lk, be, a});
                chk_val("t1_doe", data_oe, 1'b0);
                if (hold_t1) hold = 1'b1;
            end else begin
                chk_val("t2_ads", ads_n, 1'b1);
                chk_val("t2_defn", {bus_mio, bus_dc, bus_wr, lock_n, be_n, addr},
                        {t_mio, t_dc, t_wr, ~t_lk, be, a});
                chk_val("t2_doe", data_oe, t_wr);
                if (t_wr) chk_val("t2_dout", data_out, wd);
                ready_n = ((cyc - 1) <= wait_n) ? 1'b1 : 1'b0;
                data_in = din;
            end
            if (!done) @(negedge clk);
        end
        ready_n = 1'b1;
        if (!done) chk_val("rsp_timeout", 32'd0, 32'd1);
        if (hold_t1 && !rej && done) begin
            #1;
            chk_val("hold_rsp_ready", req_ready, 1'b0);
            @(negedge clk);
            chk_val("hold_grant", {hlda, bus_oe, data_oe, ads_n, req_ready}, 5'b10010);
            hold = 1'b0;
            @(negedge clk);
            #1;
            chk_val("hold_release", {hlda, bus_oe, req_ready}, 3'b011);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_val("rst_ctrl", {ads_n, lock_n, be_n, bus_oe, data_oe, hlda, rsp_valid, rsp_err, req_ready},
                {1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk_val("rst_defn", {bus_mio, bus_dc, bus_wr, addr}, 26'd0);
        chk_val("rst_data", {rsp_rdata, data_out}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk_val("rst_ready", req_ready, 1'b1);
        @(negedge clk);

        run_txn(1'b0, 1'b1, 1'b1, 1'b0, 23'h7FFFF8, 2'b00, 16'h0000, 0, 16'hEEEB, 1'b0);
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 23'h000040, 2'b10, 16'hA55A, 2, 16'h1234, 1'b0);
        run_txn(1'b0, 1'b1, 1'b1, 1'b0, 23'h001234, 2'b01, 16'h0000, TMO + 2, 16'h5555, 1'b0);
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 23'h0ABCDE, 2'b00, 16'h0000, 1, 16'hC0DE, 1'b1);
        run_txn(1'b1, 1'b1, 1'b1, 1'b0, 23'h000100, 2'b11, 16'hBEEF, 0, 16'h0000, 1'b0);
        run_txn(1'b1, 1'b1, 1'b1, 1'b1, 23'h03FF00, 2'b00, 16'h0F0F, 1, 16'h0000, 1'b0);

        // Reset in the first T2 of a locked write must abandon it silently.
        req_wr = 1'b1; req_mio = 1'b1; req_dc = 1'b1; req_lock = 1'b1;
        req_addr = 23'h2A2A2A; req_be_n = 2'b00; req_wdata = 16'h6996; req_valid = 1'b1;
        #1;
        for (int g = 0; g < 10 && !req_ready; g++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk_val("rst_pre_t2", {data_oe, lock_n}, 2'b10);
        reset_n = 1'b0;
        @(negedge clk);
        chk_val("rst_mid", {ads_n, data_oe, lock_n, rsp_valid, hlda, be_n, bus_oe},
                {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1});
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_val("rst_no_rsp", {rsp_valid, ads_n}, 2'b01);
        end

        for (int n = 0; n < 40; n++) begin
            logic [1:0] be;
            bit ht;
            be = 2'($urandom);
            ht = (be != 2'b11) && ($urandom_range(0, 5) == 0);
            run_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 23'($urandom), be,
                    16'($urandom), int'($urandom_range(0, TMO + 1)), 16'($urandom), ht);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk_val("idle_gap", {ads_n, rsp_valid, be_n}, 4'b1011);
                hold = 1'b1;
                @(negedge clk);
                chk_val("idle_hold", {hlda, bus_oe, data_oe}, 3'b100);
                hold = 1'b0;
                @(negedge clk);
                chk_val("idle_unhold", {hlda, bus_oe}, 2'b01);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
